// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// reg_pkg: shared state encoding and default width for the register family.
// Rev 1.0
// ============================================================================
package reg_pkg;

   localparam int         REG_WIDTH = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_t;

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// piso_bit_counter: loadable down-counter, tc_o flags a count of one.
// Rev 1.0
// ============================================================================
module piso_bit_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   input  logic             dec_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = value_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/piso_shift_reader.sv
`default_nettype none
// ============================================================================
// piso_shift_reader: captures a word on load/ready and shifts it out MSB first.
// Defining PISO_PARITY_EN appends one even-parity bit after bit 0. Rev 1.0
// ============================================================================
module piso_shift_reader
   import reg_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             busy,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int SH_W  = WIDTH + 1;
   localparam int CNT_W = $clog2(WIDTH + 2);
`else
   localparam int SH_W  = WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);
`endif
   localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(SH_W);

   state_t          state_q;
   logic [SH_W-1:0] shreg_q;
   logic [SH_W-1:0] shreg_d;
   logic            ready_q;
   logic            sout_q;
   logic            valid_q;
   logic            busy_q;
   logic            done_q;
   logic            cnt_load;
   logic            cnt_dec;
   logic            cnt_tc;

   // Parity rides in the LSB so it falls out naturally after bit 0.
   always_comb begin
`ifdef PISO_PARITY_EN
      shreg_d = {data_in, ^data_in};
`else
      shreg_d = data_in;
`endif
   end

   assign cnt_load = (state_q == S_IDLE) && load;
   assign cnt_dec  = (state_q == S_SHIFT);

   piso_bit_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .load_i  (cnt_load),
      .value_i (C_CNT_INIT),
      .dec_i   (cnt_dec),
      .tc_o    (cnt_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         ready_q <= 1'b1;
         sout_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  state_q <= S_SHIFT;
                  shreg_q <= shreg_d;
                  ready_q <= 1'b0;
                  sout_q  <= shreg_d[SH_W-1];
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_SHIFT: begin
               shreg_q <= {shreg_q[SH_W-2:0], 1'b0};
               if (cnt_tc) begin
                  state_q <= S_DONE;
                  sout_q  <= 1'b0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  sout_q  <= shreg_q[SH_W-2];
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               shreg_q <= '0;
               ready_q <= 1'b1;
               sout_q  <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready        = ready_q;
   assign serial_out   = sout_q;
   assign serial_valid = valid_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_reader.sv
`default_nettype none
// ============================================================================
// tb_piso_shift_reader: directed and random stimulus against a per-cycle
// expected-output schedule built from the transfer rules. Rev 1.0
// ============================================================================
module tb_piso_shift_reader;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB = W + P;

   typedef struct packed {
      logic ready;
      logic busy;
      logic valid;
      logic sout;
      logic done;
   } outs_t;

   localparam outs_t O_IDLE = '{ready: 1'b1, busy: 1'b0, valid: 1'b0, sout: 1'b0, done: 1'b0};

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         ready;
   logic         serial_out;
   logic         serial_valid;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   piso_shift_reader #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .data_in      (data_in),
      .ready        (ready),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Expected outputs for each upcoming cycle; empty means the block is idle.
   outs_t exp_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
      end else if (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
      end else if (load) begin
         for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back('{ready: 1'b0, busy: 1'b1, valid: 1'b1, sout: data_in[i], done: 1'b0});
         end
`ifdef PISO_PARITY_EN
         exp_q.push_back('{ready: 1'b0, busy: 1'b1, valid: 1'b1, sout: ^data_in, done: 1'b0});
`endif
         exp_q.push_back('{ready: 1'b0, busy: 1'b0, valid: 1'b0, sout: 1'b0, done: 1'b1});
      end
   end

   always @(negedge clk) begin
      outs_t e;
      outs_t a;
      e = (exp_q.size() != 0) ? exp_q[0] : O_IDLE;
      a = '{ready: ready, busy: busy, valid: serial_valid, sout: serial_out, done: done};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL cycle_outputs t=%0t actual(rdy,bsy,vld,out,dn)=%b expected=%b", $time, a, e);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!ready && w < 30) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", int'(ready), 1);
   endtask

   // Loads one word and measures bit stream, done cycle and ready cycle.
   task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] eb, input logic ep,
                           input bit noise);
      logic [NB-1:0] bits = '0;
      logic [W:0]    full;
      int nb = 0, done_at = 0, ready_at = 0, ndone = 0;
      full = {eb, ep};
      wait_ready();
      @(posedge clk); #1 load = 1'b1; data_in = d;
      @(posedge clk); #1 load = noise; data_in = noise ? '0 : W'($urandom);
      for (int c = 1; c <= NB + 4; c++) begin
         @(negedge clk);
         if (serial_valid) begin
            bits = {bits[NB-2:0], serial_out};
            nb++;
         end
         if (done) begin
            ndone++;
            if (done_at == 0) done_at = c;
            load = 1'b0;
         end
         if (ready && ready_at == 0) ready_at = c;
         if (noise && done_at == 0) begin
            load = 1'b1;
            data_in = '0;
         end
      end
      load = 1'b0;
      chk("bit_count", nb, NB);
      chk("bit_stream", int'(bits), int'(full[W -: NB]));
      chk("done_cycle", done_at, NB + 1);
      chk("ready_cycle", ready_at, NB + 2);
      chk("done_pulses", ndone, 1);
   endtask

   task automatic reset_mid();
      int nb = 0, ndone = 0, c = 0;
      logic [2:0] bits = '0;
      wait_ready();
      @(posedge clk); #1 load = 1'b1; data_in = 8'hA5;
      @(posedge clk); #1 load = 1'b0;
      while (nb < 3 && c < 20) begin
         @(negedge clk);
         c++;
         if (serial_valid) begin
            bits = {bits[1:0], serial_out};
            nb++;
         end
         if (done) ndone++;
      end
      chk("abort_bits", int'(bits), 5);
      #1 reset = 1'b1;
      #1 chk("abort_outputs", int'({ready, busy, serial_valid, serial_out, done}), int'(O_IDLE));
      repeat (2) begin
         @(negedge clk);
         if (done) ndone++;
      end
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run_word(8'h3C, 8'h3C, 1'b0, 1'b0);
   endtask

   task automatic hold_load();
      logic [NB-1:0] bits = '0;
      logic [W:0]    full;
      int ndone = 0, c = 0, last_done = 0;
      full = {8'h81, 1'b0};
      wait_ready();
      @(posedge clk); #1 load = 1'b1; data_in = 8'h81;
      while (ndone < 3 && c < 60) begin
         @(negedge clk);
         c++;
         if (serial_valid) bits = {bits[NB-2:0], serial_out};
         if (done) begin
            chk("hold_word", int'(bits), int'(full[W -: NB]));
            if (ndone > 0) chk("hold_period", c - last_done, NB + 2);
            last_done = c;
            ndone++;
         end
      end
      load = 1'b0;
      chk("hold_transfers", ndone, 3);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_state", int'({ready, busy, serial_valid, serial_out, done}), int'(O_IDLE));

      run_word(8'h0A, 8'h0A, 1'b0, 1'b0);
      run_word(8'hFF, 8'hFF, 1'b0, 1'b1);
      reset_mid();
      hold_load();
      run_word(8'h07, 8'h07, 1'b1, 1'b0);
      run_word(8'h03, 8'h03, 1'b0, 1'b0);
      run_word(8'h00, 8'h00, 1'b0, 1'b1);

      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         load    = ($urandom_range(0, 2) == 0);
         data_in = W'($urandom);
         reset   = ($urandom_range(0, 79) == 0);
      end
      @(posedge clk); #1 reset = 1'b0; load = 1'b0;
      repeat (NB + 4) @(posedge clk);
      @(negedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piso_shift_reader.md
Name: piso_shift_reader

Overview:
- Reader side of the team's parallel load register: captures a WIDTH-bit word on a load/ready handshake, then shifts it out serially, MSB first, one bit per clock.
- Sits downstream of register_load_store-style storage.
- Feeds serial links and bit-level consumers that need the stored byte unloaded.

Parameters:
- WIDTH, 8, data word width in bits (must be ≥ 2).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  request to capture data_in
- data_in  input  WIDTH  parallel word to serialize
- ready  output  1  block can accept a word this cycle
- serial_out  output  1  current serial bit
- serial_valid  output  1  serial_out carries a valid bit this cycle
- busy  output  1  a transfer is in progress
- done  output  1  one-cycle pulse after the last bit

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - reset is asynchronous and active-high.
  - On assertion, immediately: state=IDLE, shift register=0, counter=0, ready=1, serial_out=0, serial_valid=0, busy=0, done=0.
- States: IDLE, SHIFT, DONE. Two-bit encoding.
- IDLE:
  - ready=1.
  - If load=1 at a rising edge, capture data_in into the shift register, set counter=WIDTH, go to SHIFT.
  - If load=0, stay in IDLE.
- SHIFT:
  - serial_valid=1, busy=1, ready=0.
  - serial_out = shift register MSB (registered output, never a function of inputs).
  - Each edge: shift left with 0 fill; counter decrements.
  - When counter reaches 1 at an edge, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0, serial_valid=0, serial_out=0, ready=0.
  - Next edge: IDLE.
- Latency: load accepted at edge N →
  - bit WIDTH-1 valid in cycle N+1
  - bit 0 valid in cycle N+WIDTH
  - done in cycle N+WIDTH+1
  - ready in cycle N+WIDTH+2
- Boundary conditions:
  - load outside IDLE is ignored; data_in changes during SHIFT do not affect the output.
  - No back-to-back transfers: at least one DONE cycle and one IDLE cycle separate words.
  - serial_out=0 whenever serial_valid=0.
  - reset mid-SHIFT aborts the transfer; done is not pulsed; the next load starts clean.
  - load held high continuously: a new word is captured on every IDLE cycle, giving a period of WIDTH+2 cycles.
  - data_in all ones or all zeros: no special case.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After bit 0, one extra SHIFT cycle with serial_valid=1 and serial_out = even parity (XOR of the captured word).
  - Counter loads WIDTH+1, so done moves to cycle N+WIDTH+2.
  - CNT_W becomes $clog2(WIDTH+2).
- Undefined: no parity cycle; timing exactly as above.

Decomposition:
- Shared package/include reg_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default width constant REG_WIDTH=8
- One natural sub-module: piso_bit_counter (loadable down-counter with a terminal-count flag), parameterized by CNT_W.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset held 2 cycles, then released → ready=1, busy=0, serial_valid=0, serial_out=0, done=0.
- load=1 with data_in=8'h0A for one cycle → serial_out=0,0,0,0,1,0,1,0 over 8 valid cycles, done pulse in cycle 9, ready=1 in cycle 10.
- load 8'hFF, and during SHIFT drive load=1 with data_in=8'h00 → all 8 bits=1, second load ignored, exactly one done pulse.
- load 8'hA5, assert reset after the 3rd bit → outputs 0 immediately, no done; then load 8'h3C → clean sequence 0,0,1,1,1,1,0,0.
- load held high continuously with data_in=8'h81 → transfers repeat every 10 cycles, each 1,0,0,0,0,0,0,1.
- With PISO_PARITY_EN defined: load 8'h07 → 0,0,0,0,0,1,1,1, then parity bit 1, done in cycle 10; load 8'h03 → parity bit 0.
